// File: rtl/regfile_4x8_if.sv
// regfile_4x8_if: bus bundle for the four-entry register file.
//   master : drives we/waddr/wdata, raddr_a/raddr_b and clr;
//            observes rdata_a/rdata_b, q0..q3 and busy.
//   slave  : the register file side (directions mirrored).
// WIDTH must match the WIDTH of the attached regfile_4x8.
interface regfile_4x8_if #(
    parameter int unsigned WIDTH = 8
);
    logic             we;
    logic [1:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       raddr_a;
    logic [1:0]       raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q3;
    logic             clr;
    logic             busy;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, clr,
        input  rdata_a, rdata_b, q0, q1, q2, q3, busy
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, clr,
        output rdata_a, rdata_b, q0, q1, q2, q3, busy
    );
endinterface

// File: rtl/regfile_4x8.sv
// regfile_4x8: four-entry general-purpose register file.
//   clk        : system clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset (zeroes every entry, FSM to IDLE)
//   bus.we/waddr/wdata : synchronous write port (ignored while clearing)
//   bus.raddr_a/rdata_a, bus.raddr_b/rdata_b : combinational read ports
//   bus.q0..q3 : committed register contents, never bypassed
//   bus.clr    : one-cycle request to start the 4-cycle clear sequence
//   bus.busy   : high while the clear sequence runs
// Optional macro REGFILE_WRITE_BYPASS_EN: forwards wdata to a read port that
// addresses the entry being written in the same IDLE cycle.
module regfile_4x8 #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CLR_VALUE = 0
) (
    input logic         clk,
    input logic         rst,
    regfile_4x8_if.slave bus
);
    localparam logic [WIDTH-1:0] CLR_W = WIDTH'(CLR_VALUE);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state;
    logic [1:0]       idx;
    logic             busy_r;
    logic [WIDTH-1:0] mem [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            busy_r <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // clr takes priority over a simultaneous write
                    if (bus.clr) begin
                        state  <= CLEAR;
                        idx    <= '0;
                        busy_r <= 1'b1;
                    end else if (bus.we) begin
                        mem[bus.waddr] <= bus.wdata;
                    end
                end
                CLEAR: begin
                    mem[idx] <= CLR_W;
                    idx      <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    idx    <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic wr_live;
    always_comb begin
        wr_live = (state == IDLE) && bus.we && !bus.clr;
    end

    always_comb begin
        bus.rdata_a = mem[bus.raddr_a];
        if (wr_live && (bus.raddr_a == bus.waddr)) begin
            bus.rdata_a = bus.wdata;
        end
    end

    always_comb begin
        bus.rdata_b = mem[bus.raddr_b];
        if (wr_live && (bus.raddr_b == bus.waddr)) begin
            bus.rdata_b = bus.wdata;
        end
    end
`else
    always_comb begin
        bus.rdata_a = mem[bus.raddr_a];
        bus.rdata_b = mem[bus.raddr_b];
    end
`endif

    always_comb begin
        bus.q0   = mem[0];
        bus.q1   = mem[1];
        bus.q2   = mem[2];
        bus.q3   = mem[3];
        bus.busy = busy_r;
    end
endmodule
